// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares a single combinational ALU between PORTS requesters. Each cycle one
// eligible port is granted, its op/operands are routed to the ALU, and the
// ALU result is registered into that port's private data register together
// with a one-cycle ack pulse.
//
// Selection is round-robin starting after the last granted port. A port whose
// ack is high in the current cycle is not eligible, so a held request is
// serviced at most every other cycle and never twice for one transaction.
//
// Build option:
//   ALU_ARB_FIXED_PRI_EN  defined   -> fixed priority, lowest eligible index wins
//                         undefined -> round-robin (default)
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_req       per-port request level (operands stable while high)
//   i_op        per-port 4-bit opcode, port k at [4k+3:4k]
//   i_arg0      per-port argument 0, port k at [WIDTH*k +: WIDTH]
//   i_arg1      per-port argument 1, same packing
//   o_ack       per-port one-cycle pulse: o_data for that port just updated
//   o_data      per-port registered result, same packing as the arguments
//   o_grant     one-hot combinational grant for the current cycle (0 = idle)
//   o_alu_op    opcode to the shared ALU (NO_OP when idle)
//   o_alu_arg0  argument 0 to the shared ALU (0 when idle)
//   o_alu_arg1  argument 1 to the shared ALU (0 when idle)
//   i_alu_data  result from the shared ALU
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int PORTS = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [PORTS-1:0]         i_req,
  input  logic [4*PORTS-1:0]       i_op,
  input  logic [WIDTH*PORTS-1:0]   i_arg0,
  input  logic [WIDTH*PORTS-1:0]   i_arg1,
  output logic [PORTS-1:0]         o_ack,
  output logic [WIDTH*PORTS-1:0]   o_data,
  output logic [PORTS-1:0]         o_grant,
  output logic [3:0]               o_alu_op,
  output logic [WIDTH-1:0]         o_alu_arg0,
  output logic [WIDTH-1:0]         o_alu_arg1,
  input  logic [WIDTH-1:0]         i_alu_data
);

  localparam logic [3:0] NO_OP    = 4'h0;
  // Reset value of the last-grant pointer: port 0 is first in line.
  localparam logic [1:0] LAST_RST = 2'(PORTS - 1);

  logic [PORTS-1:0]       elig_s;
  logic [PORTS-1:0]       grant_s;
  logic [1:0]             win_s;
  logic                   found_s;
  int                     rank_s;
  int                     best_rank_s;

  logic [PORTS-1:0]       ack_r;
  logic [WIDTH*PORTS-1:0] data_r;
  logic [1:0]             last_r;

  // Winner selection: rank each eligible port by its distance after the
  // last grant (or by index in fixed-priority builds) and take the lowest.
  always_comb begin
    elig_s      = i_req & ~ack_r;
    win_s       = 2'd0;
    found_s     = 1'b0;
    rank_s      = 0;
    best_rank_s = PORTS;
    for (int k = 0; k < PORTS; k++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      rank_s = k;
`else
      rank_s = (k + PORTS - 1 - int'(last_r)) % PORTS;
`endif
      if (elig_s[k] && (rank_s < best_rank_s)) begin
        best_rank_s = rank_s;
        win_s       = 2'(k);
        found_s     = 1'b1;
      end else begin
        best_rank_s = best_rank_s;
      end
    end
    for (int k = 0; k < PORTS; k++) begin
      grant_s[k] = found_s && (win_s == 2'(k));
    end
  end

  // ALU operand mux: route the granted port, or a harmless NO_OP when idle.
  always_comb begin
    o_alu_op   = NO_OP;
    o_alu_arg0 = {WIDTH{1'b0}};
    o_alu_arg1 = {WIDTH{1'b0}};
    for (int k = 0; k < PORTS; k++) begin
      if (grant_s[k]) begin
        o_alu_op   = i_op[4*k +: 4];
        o_alu_arg0 = i_arg0[WIDTH*k +: WIDTH];
        o_alu_arg1 = i_arg1[WIDTH*k +: WIDTH];
      end else begin
        o_alu_op   = o_alu_op;
      end
    end
  end

  // Result capture, ack pulse and last-grant pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_r  <= {PORTS{1'b0}};
      data_r <= {(WIDTH*PORTS){1'b0}};
      last_r <= LAST_RST;
    end else begin
      // The ack vector is exactly the registered grant: one bit for the
      // winner, all others cleared, all cleared on an idle cycle.
      ack_r <= grant_s;
      for (int k = 0; k < PORTS; k++) begin
        if (grant_s[k]) begin
          data_r[WIDTH*k +: WIDTH] <= i_alu_data;
        end
      end
      if (found_s) begin
        last_r <= win_s;
      end
    end
  end

  assign o_grant = grant_s;
  assign o_ack   = ack_r;
  assign o_data  = data_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for alu_arbiter (PORTS=3, WIDTH=8). Provides a behavioural ALU on
// the shared-ALU ports, runs a table of directed vectors, a few hand-written
// reset sequences, then randomized requesters checked against a reference
// arbiter model.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int NP = 3;
  localparam int W  = 8;

  localparam logic [3:0] OP_NO  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_ROL = 4'h6;
  localparam logic [3:0] OP_ROR = 4'h7;
  localparam logic [3:0] OP_BAD = 4'hF;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     req;
  logic [4*NP-1:0]   op;
  logic [W*NP-1:0]   arg0;
  logic [W*NP-1:0]   arg1;
  logic [NP-1:0]     ack;
  logic [W*NP-1:0]   data;
  logic [NP-1:0]     grant;
  logic [3:0]        alu_op;
  logic [W-1:0]      alu_arg0;
  logic [W-1:0]      alu_arg1;
  logic [W-1:0]      alu_data;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural shared ALU; unknown opcodes give 0.
  function automatic logic [W-1:0] alu_f(input logic [3:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (o)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_ROL:  return {a[W-2:0], a[W-1]};
      OP_ROR:  return {a[0], a[W-1:1]};
      default: return '0;
    endcase
  endfunction

  assign alu_data = alu_f(alu_op, alu_arg0, alu_arg1);

  alu_arbiter #(.WIDTH(W), .PORTS(NP)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_op       (op),
    .i_arg0     (arg0),
    .i_arg1     (arg1),
    .o_ack      (ack),
    .o_data     (data),
    .o_grant    (grant),
    .o_alu_op   (alu_op),
    .o_alu_arg0 (alu_arg0),
    .o_alu_arg1 (alu_arg1),
    .i_alu_data (alu_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  typedef struct packed {
    logic [NP-1:0]   req;
    logic [4*NP-1:0] op;
    logic [W*NP-1:0] a0;
    logic [W*NP-1:0] a1;
    logic [NP-1:0]   eg;
    logic [W-1:0]    er;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] r,
                              input logic [3:0] o0, input logic [7:0] x0, input logic [7:0] y0,
                              input logic [3:0] o1, input logic [7:0] x1, input logic [7:0] y1,
                              input logic [3:0] o2, input logic [7:0] x2, input logic [7:0] y2,
                              input logic [2:0] eg, input logic [7:0] er);
    vec_t v;
    v.req = r;
    v.op  = {o2, o1, o0};
    v.a0  = {x2, x1, x0};
    v.a1  = {y2, y1, y0};
    v.eg  = eg;
    v.er  = er;
    return v;
  endfunction

  // Called at a negedge with inputs already driven: checks the combinational
  // grant / ALU drive, then the registered ack and winner's data after the edge.
  task automatic step_check(input logic [NP-1:0] eg, input logic [W-1:0] er, input string tag);
    #2;
    chk({tag, " grant"}, 32'(grant), 32'(eg));
    if (eg == '0) begin
      chk({tag, " idle alu drive"}, {alu_op, alu_arg0, alu_arg1}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk({tag, " ack"}, 32'(ack), 32'(eg));
    for (int k = 0; k < NP; k++) begin
      if (eg[k]) chk({tag, " data"}, 32'(data[W*k +: W]), 32'(er));
    end
    @(negedge clk);
  endtask

  vec_t        tbl[12];
  logic [NP-1:0] m_ack;
  logic [W-1:0]  m_data [NP];
  int            m_last;
  int            w;
  int            idx;

  initial begin
    rst  = 1'b1;
    req  = '0;
    op   = '0;
    arg0 = '0;
    arg1 = '0;

    // Directed vectors, starting from reset state (last = port 2).
    tbl[0]  = mk(3'b001, OP_ADD, 8'h03, 8'h04, OP_NO,  8'h00, 8'h00, OP_NO,  8'h00, 8'h00, 3'b001, 8'h07);
    tbl[1]  = mk(3'b001, OP_ADD, 8'h03, 8'h04, OP_NO,  8'h00, 8'h00, OP_NO,  8'h00, 8'h00, 3'b000, 8'h00);
    tbl[2]  = mk(3'b001, OP_ADD, 8'h03, 8'h04, OP_NO,  8'h00, 8'h00, OP_NO,  8'h00, 8'h00, 3'b001, 8'h07);
    tbl[3]  = mk(3'b010, OP_ADD, 8'h03, 8'h04, OP_SUB, 8'h00, 8'h01, OP_NO,  8'h00, 8'h00, 3'b010, 8'hFF);
    tbl[4]  = mk(3'b011, OP_ROL, 8'h81, 8'h00, OP_SUB, 8'h00, 8'h01, OP_NO,  8'h00, 8'h00, 3'b001, 8'h03);
    tbl[5]  = mk(3'b011, OP_ROL, 8'h81, 8'h00, OP_SUB, 8'h00, 8'h01, OP_NO,  8'h00, 8'h00, 3'b010, 8'hFF);
    tbl[6]  = mk(3'b100, OP_ROL, 8'h81, 8'h00, OP_SUB, 8'h00, 8'h01, OP_BAD, 8'h05, 8'h06, 3'b100, 8'h00);
    tbl[7]  = mk(3'b000, OP_ROL, 8'h81, 8'h00, OP_SUB, 8'h00, 8'h01, OP_BAD, 8'h05, 8'h06, 3'b000, 8'h00);
    tbl[8]  = mk(3'b111, OP_ADD, 8'hFF, 8'h02, OP_XOR, 8'hF0, 8'h3C, OP_AND, 8'hF0, 8'h3C, 3'b001, 8'h01);
    tbl[9]  = mk(3'b111, OP_ADD, 8'hFF, 8'h02, OP_XOR, 8'hF0, 8'h3C, OP_AND, 8'hF0, 8'h3C, 3'b010, 8'hCC);
`ifdef ALU_ARB_FIXED_PRI_EN
    tbl[10] = mk(3'b111, OP_ADD, 8'hFF, 8'h02, OP_XOR, 8'hF0, 8'h3C, OP_AND, 8'hF0, 8'h3C, 3'b001, 8'h01);
    tbl[11] = mk(3'b111, OP_ADD, 8'hFF, 8'h02, OP_XOR, 8'hF0, 8'h3C, OP_AND, 8'hF0, 8'h3C, 3'b010, 8'hCC);
`else
    tbl[10] = mk(3'b111, OP_ADD, 8'hFF, 8'h02, OP_XOR, 8'hF0, 8'h3C, OP_AND, 8'hF0, 8'h3C, 3'b100, 8'h30);
    tbl[11] = mk(3'b111, OP_ADD, 8'hFF, 8'h02, OP_XOR, 8'hF0, 8'h3C, OP_AND, 8'hF0, 8'h3C, 3'b001, 8'h01);
`endif

    // Reset state.
    #12;
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset data", 32'(data), 32'd0);
    chk("reset grant idle", 32'(grant), 32'd0);
    chk("reset alu op", 32'(alu_op), 32'(OP_NO));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      req  = tbl[i].req;
      op   = tbl[i].op;
      arg0 = tbl[i].a0;
      arg1 = tbl[i].a1;
      step_check(tbl[i].eg, tbl[i].er, $sformatf("vec%0d", i));
    end

    // Async reset while port 1 is being acked.
    req  = 3'b010;
    op   = {OP_NO, OP_SUB, OP_ADD};
    arg0 = {8'h00, 8'h00, 8'h03};
    arg1 = {8'h00, 8'h01, 8'h04};
    step_check(3'b010, 8'hFF, "pre-reset p1");
    rst = 1'b1;
    #1;
    chk("async reset ack", 32'(ack), 32'd0);
    chk("async reset data", 32'(data), 32'd0);
    @(posedge clk);
    #1;
    chk("held reset ack", 32'(ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 3'b000;
    step_check(3'b000, 8'h00, "post-reset idle");
    chk("post-reset data stable", 32'(data), 32'd0);
    req = 3'b010;
    step_check(3'b010, 8'hFF, "re-request p1");

    // Short reset pulse between edges; first grant must go to port 0.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req = 3'b111;
    step_check(3'b001, 8'h07, "first grant after reset");

    // Randomized requesters against the reference model.
    req = '0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_ack  = '0;
    m_last = NP - 1;
    for (int k = 0; k < NP; k++) m_data[k] = '0;
    @(negedge clk);
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NP; k++) begin
        if (!req[k]) begin
          if ($urandom_range(0, 1) == 1) begin
            req[k]        = 1'b1;
            op[4*k +: 4]  = 4'($urandom_range(0, 15));
            arg0[W*k +: W] = W'($urandom);
            arg1[W*k +: W] = W'($urandom);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          req[k] = 1'b0;
        end
      end
      w = -1;
`ifdef ALU_ARB_FIXED_PRI_EN
      for (int k = 0; k < NP; k++) begin
        if (w < 0 && req[k] && !m_ack[k]) w = k;
      end
`else
      for (int i = 1; i <= NP; i++) begin
        idx = (m_last + i) % NP;
        if (w < 0 && req[idx] && !m_ack[idx]) w = idx;
      end
`endif
      #2;
      if (w < 0) begin
        chk("rand grant", 32'(grant), 32'd0);
        chk("rand alu drive idle", {alu_op, alu_arg0, alu_arg1}, 32'd0);
      end else begin
        chk("rand grant", 32'(grant), 32'(1) << w);
        chk("rand alu drive", {alu_op, alu_arg0, alu_arg1},
            {12'd0, op[4*w +: 4], arg0[W*w +: W], arg1[W*w +: W]});
      end
      @(posedge clk);
      #1;
      if (w < 0) begin
        m_ack = '0;
      end else begin
        m_ack     = NP'(1) << w;
        m_data[w] = alu_f(op[4*w +: 4], arg0[W*w +: W], arg1[W*w +: W]);
        m_last    = w;
      end
      chk("rand ack", 32'(ack), 32'(m_ack));
      chk("rand data", 32'(data), {8'd0, m_data[2], m_data[1], m_data[0]});
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
